// File: rtl/step_ctrl.sv
// Clock-enable generator for the multicycle processor: debounced single-step,
// slow free-run and full-speed run. Also counts issued steps and stops on halt.
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_W            = 20,
    parameter int RUN_DIV         = 8,
    parameter int DIV_W           = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_step,
    input  logic [1:0]  sw_mode,
    input  logic        halt_in,
    output logic        step_en,
    output logic [15:0] step_count,
    output logic [2:0]  state_o,
    output logic        key_db
);

    typedef enum logic [2:0] {
        STEP_WAIT = 3'b000,
        RUN_SLOW  = 3'b001,
        RUN_FAST  = 3'b010,
        STOPPED   = 3'b011,
        HALTED    = 3'b100
    } state_t;

    state_t state_q, state_d, mode_state;

    logic             ks_meta_q, ks_meta_d, ks_q, ks_d;
    logic [1:0]       ms_meta_q, ms_meta_d, ms_q, ms_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic             key_db_q, key_db_d;
    logic             key_db_prev_q, key_db_prev_d;
    logic             halt_q, halt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             step_en_q, step_en_d;
    logic [15:0]      step_count_q, step_count_d;

    logic press;
    logic halt_rise;

    // Two-flop synchronizers and the halt edge history.
    always_comb begin
        ks_meta_d = key_step;
        ks_d      = ks_meta_q;
        ms_meta_d = sw_mode;
        ms_d      = ms_meta_q;
        halt_d    = halt_in;
    end

    assign halt_rise = halt_in & ~halt_q;
    assign press     = key_db_q & ~key_db_prev_q;

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        cnt_d         = '0;
        key_db_d      = key_db_q;
        key_db_prev_d = key_db_q;
        if (ks_q != key_db_q) begin
            if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_db_d = ks_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        mode_state = STEP_WAIT;
        case (ms_q)
            2'b00: mode_state = STEP_WAIT;
            2'b01: mode_state = RUN_SLOW;
            2'b10: mode_state = RUN_FAST;
            2'b11: mode_state = STOPPED;
            default: mode_state = STEP_WAIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= STEP_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // HALTED is sticky: only a debounced press leaves it, back to the switch mode.
    always_comb begin
        state_d = state_q;
        if (state_q == HALTED) begin
            if (press) begin
                state_d = mode_state;
            end
        end else if (halt_rise) begin
            state_d = HALTED;
        end else begin
            state_d = mode_state;
        end
    end

    always_comb begin
        step_en_d = 1'b0;
        unique case (state_q)
            STEP_WAIT: step_en_d = press;
            RUN_SLOW:  step_en_d = (div_q == DIV_W'(RUN_DIV - 1));
            RUN_FAST:  step_en_d = 1'b1;
            STOPPED:   step_en_d = 1'b0;
            HALTED:    step_en_d = 1'b0;
            default:   step_en_d = 1'b0;
        endcase
        if (halt_rise && state_q != HALTED) begin
            step_en_d = 1'b0;
        end
    end

    // Divider restarts from zero whenever RUN_SLOW is (re)entered.
    always_comb begin
        div_d = '0;
        if (state_q == RUN_SLOW && state_d == RUN_SLOW && div_q != DIV_W'(RUN_DIV - 1)) begin
            div_d = div_q + 1'b1;
        end
        step_count_d = step_en_q ? step_count_q + 16'd1 : step_count_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ks_meta_q     <= 1'b0;
            ks_q          <= 1'b0;
            ms_meta_q     <= 2'b00;
            ms_q          <= 2'b00;
            cnt_q         <= '0;
            key_db_q      <= 1'b0;
            key_db_prev_q <= 1'b0;
            halt_q        <= 1'b0;
            div_q         <= '0;
            step_en_q     <= 1'b0;
            step_count_q  <= 16'd0;
        end else begin
            ks_meta_q     <= ks_meta_d;
            ks_q          <= ks_d;
            ms_meta_q     <= ms_meta_d;
            ms_q          <= ms_d;
            cnt_q         <= cnt_d;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_prev_d;
            halt_q        <= halt_d;
            div_q         <= div_d;
            step_en_q     <= step_en_d;
            step_count_q  <= step_count_d;
        end
    end

    assign step_en    = step_en_q;
    assign step_count = step_count_q;
    assign state_o    = state_q;
    assign key_db     = key_db_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: button latency and bounce, slow/fast run,
// counter wrap, halt entry/exit and asynchronous reset.
module tb_step_ctrl;

    logic        clock;
    logic        reset;
    logic        key_step;
    logic [1:0]  sw_mode;
    logic        halt_in;
    logic        step_en;
    logic [15:0] step_count;
    logic [2:0]  state_o;
    logic        key_db;

    int tests_run = 0;
    int failures  = 0;

    int pulses, first_at, bad_gaps, bounce_pulses, low_cycles;

    step_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .DB_W(20),
        .RUN_DIV(8),
        .DIV_W(24)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_step(key_step),
        .sw_mode(sw_mode),
        .halt_in(halt_in),
        .step_en(step_en),
        .step_count(step_count),
        .state_o(state_o),
        .key_db(key_db)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic key, input logic [1:0] mode, input logic halt);
        key_step = key;
        sw_mode  = mode;
        halt_in  = halt;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Step through n edges, noting pulse count, first pulse edge and spacing.
    task automatic runWindow(input int n, input int period, output int cnt, output int first, output int bad);
        int last;
        cnt = 0; first = 0; bad = 0; last = 0;
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (step_en) begin
                if (cnt == 0) first = i;
                else if (period != 0 && (i - last) != period) bad++;
                last = i;
                cnt++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0);
        tick(2);
        checkOutput("reset_step_en", 32'(step_en), 32'd0);
        checkOutput("reset_count", 32'(step_count), 32'd0);
        checkOutput("reset_state", 32'(state_o), 32'd0);
        checkOutput("reset_key_db", 32'(key_db), 32'd0);

        // Clean 40-cycle press in single-step mode.
        reset = 1'b0;
        applyStimulus(1'b1, 2'b00, 1'b0);
        tick(17);
        checkOutput("clean_key_db_e17", 32'(key_db), 32'd0);
        tick(1);
        checkOutput("clean_key_db_e18", 32'(key_db), 32'd1);
        checkOutput("clean_step_en_e18", 32'(step_en), 32'd0);
        tick(1);
        checkOutput("clean_step_en_e19", 32'(step_en), 32'd1);
        tick(1);
        checkOutput("clean_step_en_e20", 32'(step_en), 32'd0);
        checkOutput("clean_count", 32'(step_count), 32'd1);
        runWindow(20, 0, pulses, first_at, bad_gaps);
        checkOutput("clean_hold_pulses", 32'(pulses), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b0);
        runWindow(40, 0, pulses, first_at, bad_gaps);
        checkOutput("release_pulses", 32'(pulses), 32'd0);
        checkOutput("release_key_db", 32'(key_db), 32'd0);
        checkOutput("release_count", 32'(step_count), 32'd1);

        // Five 3-cycle bounces, then a stable 30-cycle hold.
        bounce_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'b00, 1'b0);
            runWindow(3, 0, pulses, first_at, bad_gaps);
            bounce_pulses += pulses;
            applyStimulus(1'b0, 2'b00, 1'b0);
            runWindow(3, 0, pulses, first_at, bad_gaps);
            bounce_pulses += pulses;
        end
        checkOutput("bounce_glitch_pulses", 32'(bounce_pulses), 32'd0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        runWindow(30, 0, pulses, first_at, bad_gaps);
        checkOutput("bounce_hold_pulses", 32'(pulses), 32'd1);
        checkOutput("bounce_pulse_edge", 32'(first_at), 32'd19);
        applyStimulus(1'b0, 2'b00, 1'b0);
        runWindow(40, 0, pulses, first_at, bad_gaps);
        checkOutput("bounce_release_pulses", 32'(pulses), 32'd0);
        checkOutput("bounce_count", 32'(step_count), 32'd2);

        // Slow run: entry three edges after the switch change, period 8.
        applyStimulus(1'b0, 2'b01, 1'b0);
        tick(2);
        checkOutput("slow_state_e2", 32'(state_o), 32'd0);
        tick(1);
        checkOutput("slow_state_e3", 32'(state_o), 32'd1);
        runWindow(80, 8, pulses, first_at, bad_gaps);
        checkOutput("slow_pulses", 32'(pulses), 32'd10);
        checkOutput("slow_first_pulse", 32'(first_at), 32'd8);
        checkOutput("slow_bad_gaps", 32'(bad_gaps), 32'd0);
        tick(4);
        checkOutput("slow_count", 32'(step_count), 32'd12);
        applyStimulus(1'b0, 2'b11, 1'b0);
        runWindow(30, 0, pulses, first_at, bad_gaps);
        checkOutput("stop_pulses", 32'(pulses), 32'd0);
        checkOutput("stop_state", 32'(state_o), 32'd3);
        checkOutput("stop_count", 32'(step_count), 32'd12);

        // Fast run through the 16-bit wrap.
        reset = 1'b1;
        tick(2);
        checkOutput("rst2_count", 32'(step_count), 32'd0);
        reset = 1'b0;
        tick(4);
        checkOutput("rst2_state_stopped", 32'(state_o), 32'd3);
        applyStimulus(1'b0, 2'b10, 1'b0);
        tick(4);
        checkOutput("fast_state", 32'(state_o), 32'd2);
        checkOutput("fast_first_step_en", 32'(step_en), 32'd1);
        checkOutput("fast_count_start", 32'(step_count), 32'd0);
        low_cycles = 0;
        for (int i = 0; i < 65535; i++) begin
            tick(1);
            if (!step_en) low_cycles++;
        end
        checkOutput("fast_low_cycles", 32'(low_cycles), 32'd0);
        checkOutput("fast_count_ffff", 32'(step_count), 32'hFFFF);
        tick(1);
        checkOutput("fast_count_wrap", 32'(step_count), 32'd0);
        tick(4);
        checkOutput("fast_count_4", 32'(step_count), 32'd4);

        // Halt from RUN_FAST, ignore re-halts and mode changes, exit on press.
        applyStimulus(1'b0, 2'b10, 1'b1);
        tick(1);
        checkOutput("halt_state", 32'(state_o), 32'd4);
        checkOutput("halt_step_en", 32'(step_en), 32'd0);
        checkOutput("halt_count", 32'(step_count), 32'd5);
        tick(1);
        checkOutput("halt_count_hold", 32'(step_count), 32'd5);
        applyStimulus(1'b0, 2'b10, 1'b0);
        tick(2);
        applyStimulus(1'b0, 2'b10, 1'b1);
        tick(3);
        checkOutput("rehalt_state", 32'(state_o), 32'd4);
        checkOutput("rehalt_step_en", 32'(step_en), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b1);
        tick(5);
        checkOutput("halt_mode_ignored", 32'(state_o), 32'd4);
        applyStimulus(1'b0, 2'b10, 1'b0);
        tick(3);
        applyStimulus(1'b1, 2'b10, 1'b0);
        tick(18);
        checkOutput("exit_state_e18", 32'(state_o), 32'd4);
        tick(1);
        checkOutput("exit_state_e19", 32'(state_o), 32'd2);
        checkOutput("exit_step_en_e19", 32'(step_en), 32'd0);
        tick(1);
        checkOutput("exit_step_en_e20", 32'(step_en), 32'd1);
        checkOutput("exit_count_e20", 32'(step_count), 32'd5);
        tick(1);
        checkOutput("exit_count_e21", 32'(step_count), 32'd6);
        applyStimulus(1'b0, 2'b10, 1'b0);

        // Asynchronous reset mid-RUN_SLOW and mid-debounce.
        reset = 1'b1;
        applyStimulus(1'b0, 2'b01, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(25);
        applyStimulus(1'b1, 2'b01, 1'b0);
        tick(10);
        checkOutput("pre_areset_step_en", 32'(step_en), 32'd1);
        checkOutput("pre_areset_count", 32'(step_count), 32'd3);
        checkOutput("pre_areset_state", 32'(state_o), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("areset_step_en", 32'(step_en), 32'd0);
        checkOutput("areset_count", 32'(step_count), 32'd0);
        checkOutput("areset_state", 32'(state_o), 32'd0);
        checkOutput("areset_key_db", 32'(key_db), 32'd0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        tick(1);
        reset = 1'b0;
        runWindow(40, 0, pulses, first_at, bad_gaps);
        checkOutput("held_through_reset_pulses", 32'(pulses), 32'd1);
        checkOutput("held_through_reset_edge", 32'(first_at), 32'd19);
        checkOutput("held_through_reset_count", 32'(step_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
